// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared opcodes and FSM encoding for the HI/LO multiply/divide sequencer.
package muldiv_hilo_ctrl_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_RUN = 2'd1,
        ST_DIV_FIX = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic isDivOp(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// EX-stage bundle between the pipeline and the muldiv/HI-LO sequencer.
interface muldiv_hilo_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             stall_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output op_valid, op, src_a, src_b, flush,
        input  stall_o, hi_o, lo_o
    );

    modport slave (
        input  op_valid, op, src_a, src_b, flush,
        output stall_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_hilo_ctrl_div_step.sv
// One radix-2 restoring division iteration on magnitudes, purely combinational.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_shiftRem;
    logic [WIDTH:0] w_diff;

    // rem < divisor on entry, so the shifted value always fits in WIDTH+1 bits
    assign w_shiftRem = {i_rem, i_quo[WIDTH-1]};
    assign w_diff     = w_shiftRem - {1'b0, i_divisor};

    always_comb begin
        o_rem = w_shiftRem[WIDTH-1:0];
        o_quo = {i_quo[WIDTH-2:0], 1'b0};
        if (!w_diff[WIDTH]) begin
            o_rem = w_diff[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning HI/LO; divides stall EX for 34 cycles.
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_hilo_ctrl_if.slave bus
);
    localparam int             CW        = $clog2(DIV_STEPS);
    localparam logic [CW-1:0]  LAST_STEP = CW'(DIV_STEPS - 1);

    state_t               r_state;
    state_t               w_nextState;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_divisor;
    logic [CW-1:0]        r_count;
    logic                 r_signQ;
    logic                 r_signR;
    logic                 w_stall;
    logic                 w_isSigned;
    logic                 w_negA;
    logic                 w_negB;
    logic                 w_bNonZero;
    logic [WIDTH-1:0]     w_stepRem;
    logic [WIDTH-1:0]     w_stepQuo;
    logic [2*WIDTH-1:0]   w_prodS;
    logic [2*WIDTH-1:0]   w_prodU;

    assign w_isSigned = (bus.op == MD_DIV);
    assign w_negA     = w_isSigned & bus.src_a[WIDTH-1];
    assign w_negB     = w_isSigned & bus.src_b[WIDTH-1];
    assign w_bNonZero = |bus.src_b;

    // Operands are widened explicitly so the 2*WIDTH product keeps every bit
    assign w_prodS = $signed({{WIDTH{bus.src_a[WIDTH-1]}}, bus.src_a})
                   * $signed({{WIDTH{bus.src_b[WIDTH-1]}}, bus.src_b});
    assign w_prodU = {{WIDTH{1'b0}}, bus.src_a} * {{WIDTH{1'b0}}, bus.src_b};

    div_step #(.WIDTH(WIDTH)) u_divStep (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_stepRem),
        .o_quo     (w_stepQuo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (bus.flush) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:
                    if (bus.op_valid && isDivOp(bus.op))
                        w_nextState = w_bNonZero ? ST_DIV_RUN : ST_DONE;
                ST_DIV_RUN:
                    if (r_count == LAST_STEP) w_nextState = ST_DIV_FIX;
                ST_DIV_FIX: w_nextState = ST_DONE;
                default:    w_nextState = ST_IDLE;
            endcase
        end
    end

    // Flush kills the stall immediately so the exception redirect is not held off
    always_comb begin
        w_stall = 1'b0;
        if (!bus.flush) begin
            case (r_state)
                ST_IDLE:                w_stall = bus.op_valid && isDivOp(bus.op);
                ST_DIV_RUN, ST_DIV_FIX: w_stall = 1'b1;
                default:                w_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_signQ   <= 1'b0;
            r_signR   <= 1'b0;
        end else if (!bus.flush) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.op_valid) begin
                        case (bus.op)
                            MD_MULT: begin
                                r_hi <= w_prodS[2*WIDTH-1:WIDTH];
                                r_lo <= w_prodS[WIDTH-1:0];
                            end
                            MD_MULTU: begin
                                r_hi <= w_prodU[2*WIDTH-1:WIDTH];
                                r_lo <= w_prodU[WIDTH-1:0];
                            end
                            MD_MTHI: r_hi <= bus.src_a;
                            MD_MTLO: r_lo <= bus.src_a;
                            MD_DIV, MD_DIVU: begin
                                if (w_bNonZero) begin
                                    r_quo     <= w_negA ? -bus.src_a : bus.src_a;
                                    r_divisor <= w_negB ? -bus.src_b : bus.src_b;
                                    r_rem     <= '0;
                                    r_count   <= '0;
                                    r_signQ   <= w_negA ^ w_negB;
                                    r_signR   <= w_negA;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_DIV_RUN: begin
                    r_rem   <= w_stepRem;
                    r_quo   <= w_stepQuo;
                    r_count <= r_count + CW'(1);
                end
                ST_DIV_FIX: begin
                    r_lo <= r_signQ ? -r_quo : r_quo;
                    r_hi <= r_signR ? -r_rem : r_rem;
                end
                default: ;
            endcase
        end
    end

    assign bus.stall_o = w_stall;
    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed plus randomized checks of muldiv_hilo_ctrl against a plain-arithmetic HI/LO model.
module tb_muldiv_hilo_ctrl;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    int   fails;
    logic [31:0] mHi;
    logic [31:0] mLo;

    muldiv_hilo_ctrl_if #(.WIDTH(32)) bus ();

    muldiv_hilo_ctrl #(.WIDTH(32), .DIV_STEPS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] o,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic f);
        bus.op_valid = v;
        bus.op       = o;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.flush    = f;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Architectural result of one completed instruction, straight from the ISA rules
    task automatic modelOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        sa = a;
        sb = b;
        case (o)
            OP_MULT: begin
                sp = longint'(sa) * longint'(sb);
                {mHi, mLo} = sp;
            end
            OP_MULTU: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                {mHi, mLo} = up;
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    mLo = 32'h8000_0000;
                    mHi = 32'd0;
                end else begin
                    mLo = sa / sb;
                    mHi = sa % sb;
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) begin
                    mLo = a / b;
                    mHi = a % b;
                end
            end
            OP_MTHI: mHi = a;
            OP_MTLO: mLo = a;
            default: ;
        endcase
    endtask

    task automatic runSingle(input string tag, input logic [2:0] o,
                             input logic [31:0] a, input logic [31:0] b);
        applyStimulus(1'b1, o, a, b, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_stall"}, {31'd0, bus.stall_o}, 32'd0);
        tick();
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        modelOp(o, a, b);
        @(negedge clk);
        checkOutput({tag, "_hi"}, bus.hi_o, mHi);
        checkOutput({tag, "_lo"}, bus.lo_o, mLo);
        tick();
    endtask

    // flushAt=0 runs to completion; otherwise flush is raised in that stall cycle
    task automatic runDiv(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b, input int flushAt);
        int   n;
        logic done;
        int   expStall;
        n    = 0;
        done = 1'b0;
        applyStimulus(1'b1, o, a, b, 1'b0);
        for (int c = 1; c <= 60 && !done; c++) begin
            if (flushAt != 0 && c == flushAt) bus.flush = 1'b1;
            @(negedge clk);
            if (bus.stall_o) begin
                n++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        checkOutput({tag, "_finished"}, {31'd0, done}, 32'd1);
        if (flushAt != 0)      expStall = flushAt - 1;
        else if (b == 32'd0)   expStall = 1;
        else                   expStall = 34;
        checkOutput({tag, "_stallcycles"}, n, expStall);
        if (flushAt == 0) modelOp(o, a, b);
        checkOutput({tag, "_hi"}, bus.hi_o, mHi);
        checkOutput({tag, "_lo"}, bus.lo_o, mLo);
        tick();
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        checks = 0;
        passes = 0;
        fails  = 0;
        mHi    = 32'd0;
        mLo    = 32'd0;
        rst_n  = 1'b0;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        #12;
        checkOutput("reset_hi", bus.hi_o, 32'd0);
        checkOutput("reset_lo", bus.lo_o, 32'd0);
        checkOutput("reset_stall", {31'd0, bus.stall_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        runDiv("divu_100_7", OP_DIVU, 32'd100, 32'd7, 0);
        checkOutput("divu_100_7_lo_const", bus.lo_o, 32'd14);
        checkOutput("divu_100_7_hi_const", bus.hi_o, 32'd2);
        runDiv("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        checkOutput("div_m7_2_lo_const", bus.lo_o, 32'hFFFF_FFFD);
        checkOutput("div_m7_2_hi_const", bus.hi_o, 32'hFFFF_FFFF);
        runDiv("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        checkOutput("div_ovf_lo_const", bus.lo_o, 32'h8000_0000);

        runSingle("mult_m1_2", OP_MULT, 32'hFFFF_FFFF, 32'd2);
        checkOutput("mult_hi_const", bus.hi_o, 32'hFFFF_FFFF);
        runSingle("multu_m1_2", OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        checkOutput("multu_hi_const", bus.hi_o, 32'd1);
        checkOutput("multu_lo_const", bus.lo_o, 32'hFFFF_FFFE);

        runSingle("mthi", OP_MTHI, 32'h11, 32'd0);
        runSingle("mtlo", OP_MTLO, 32'h22, 32'd0);
        runDiv("divu_flush", OP_DIVU, 32'd1000, 32'd13, 10);
        checkOutput("flush_hi_const", bus.hi_o, 32'h11);
        checkOutput("flush_lo_const", bus.lo_o, 32'h22);
        runDiv("divu_9_3", OP_DIVU, 32'd9, 32'd3, 0);
        checkOutput("divu_9_3_lo_const", bus.lo_o, 32'd3);

        runDiv("div_by0", OP_DIV, 32'd55, 32'd0, 0);
        runDiv("divu_after_by0", OP_DIVU, 32'd100, 32'd7, 0);
        runSingle("op6_ignored", 3'd6, 32'hDEAD_BEEF, 32'h1234);

        // Async reset in the middle of a divide
        applyStimulus(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        #1;
        mHi = 32'd0;
        mLo = 32'd0;
        checkOutput("midrst_hi", bus.hi_o, 32'd0);
        checkOutput("midrst_lo", bus.lo_o, 32'd0);
        checkOutput("midrst_stall", {31'd0, bus.stall_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        runDiv("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 0);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end else if (sel == 2) rb = $urandom_range(1, 15);
            if (rop == OP_DIV || rop == OP_DIVU) runDiv($sformatf("rnd%0d_div", i), rop, ra, rb, 0);
            else runSingle($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
